seqdet_scan_ctrl: RTL and testbench

Word-to-serial scan controller for the serial pattern detector family.
- Accepts parallel words over a valid/ready handshake and shifts each one out MSB-first, one bit per clock.
- Runs a runtime-configurable pattern matcher on that bit stream, with overlap or non-overlap detection and a saturating match counter.
- Sits between a bus-side producer and serial consumers. It is the block that sequences the detector and configures its pattern.

---
 rtl/seqdet_scan_ctrl_pkg.sv | 13 +
 rtl/seqdet_scan_ctrl_if.sv | 12 +
 rtl/seqdet_scan_ctrl_pat_match.sv | 77 +++++++
 rtl/seqdet_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seqdet_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seqdet_scan_ctrl_pkg.sv
// Shared types and reset constants for the serial pattern detector scan controller.
package seqdet_scan_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [4:0] DEF_PATTERN = 5'b10110;
    localparam int unsigned DEF_LEN    = 5;
    localparam logic       DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seqdet_scan_ctrl_if.sv
// Word handshake between a bus-side producer and the scan controller.
interface seqdet_scan_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/seqdet_scan_ctrl_pat_match.sv
// Runtime-configurable serial pattern matcher: shift history, fill level and a
// registered match pulse aligned with the completing bit.
module seqdet_pat_match
    import seqdet_scan_ctrl_pkg::*;
#(
    parameter int PAT_W = 5,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_i,
    input  logic             bit_i,
    input  logic             clear_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             overlap_i,
    output logic             hit_o,
    output logic             match_o
);

    logic [PAT_W-1:0] hist_q, hist_d, next_hist, mask_s;
    logic [LEN_W-1:0] fill_q, fill_d, next_fill;
    logic             match_q, hit_s;

    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PAT_W-1:0] m;
        for (int k = 0; k < PAT_W; k++) begin
            m[k] = (k < int'(len));
        end
        return m;
    endfunction

    // Next history/fill and the comparison against the low len bits of the pattern.
    always_comb begin
        next_hist = {hist_q[PAT_W-2:0], bit_i};
        if (fill_q == LEN_W'(PAT_W)) begin
            next_fill = fill_q;
        end else begin
            next_fill = fill_q + LEN_W'(1);
        end
        mask_s = len_mask(len_i);
        hit_s  = strobe_i && (len_i != {LEN_W{1'b0}}) && (next_fill >= len_i) &&
                 (((next_hist ^ pattern_i) & mask_s) == {PAT_W{1'b0}});
        hist_d = hist_q;
        fill_d = fill_q;
        if (strobe_i) begin
            hist_d = next_hist;
            // Clearing fill alone is enough to suppress overlap; stale history is gated.
            fill_d = (hit_s && !overlap_i) ? {LEN_W{1'b0}} : next_fill;
        end else begin
            hist_d = hist_q;
        end
        if (clear_i) begin
            hist_d = {PAT_W{1'b0}};
            fill_d = {LEN_W{1'b0}};
        end else begin
            fill_d = fill_d;
        end
    end

    // Matcher state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= {PAT_W{1'b0}};
            fill_q  <= {LEN_W{1'b0}};
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= hit_s;
        end
    end

    assign hit_o   = hit_s;
    assign match_o = match_q;

endmodule

// File: rtl/seqdet_scan_ctrl.sv
// Word-to-serial scan controller: accepts words over valid/ready, shifts them out
// MSB-first and drives the pattern matcher, match counter and end-of-stream pulse.
module seqdet_scan_ctrl
    import seqdet_scan_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 5,
    parameter int CNT_W  = 8,
    localparam int LEN_W = $clog2(PAT_W + 1),
    localparam int BIT_W = $clog2(DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    seqdet_scan_ctrl_if.slave   in_bus,
    input  logic                cfg_we_i,
    input  logic [PAT_W-1:0]    cfg_pattern_i,
    input  logic [LEN_W-1:0]    cfg_len_i,
    input  logic                cfg_overlap_i,
    output logic                serial_bit_o,
    output logic                serial_valid_o,
    output logic                match_o,
    output logic [CNT_W-1:0]    match_count_o,
    output logic                busy_o,
    output logic                done_o
);

    state_e            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BIT_W-1:0]  bitcnt_q;
    logic              last_q, sbit_q, svalid_q, eos_q, done_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ovl_q, ovl_d;
    logic              cfg_take_s, accept_s, strobe_s, flush_s, hit_s, clear_s;

    assign cfg_take_s = cfg_we_i && (state_q == IDLE);
    assign accept_s   = in_bus.valid && (state_q == IDLE);
    assign strobe_s   = (state_q == SHIFT);
    assign flush_s    = strobe_s && (bitcnt_q == {BIT_W{1'b0}}) && last_q;
    assign clear_s    = cfg_take_s || flush_s;

    // Handshake, shift register and serial output sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= {DATA_W{1'b0}};
            bitcnt_q <= {BIT_W{1'b0}};
            last_q   <= 1'b0;
            sbit_q   <= 1'b0;
            svalid_q <= 1'b0;
            eos_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            svalid_q <= 1'b0;
            eos_q    <= flush_s;
            done_q   <= eos_q;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        shreg_q  <= in_bus.data;
                        last_q   <= in_bus.last;
                        bitcnt_q <= BIT_W'(DATA_W - 1);
                        state_q  <= SHIFT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SHIFT: begin
                    sbit_q   <= shreg_q[DATA_W-1];
                    svalid_q <= 1'b1;
                    shreg_q  <= {shreg_q[DATA_W-2:0], 1'b0};
                    bitcnt_q <= bitcnt_q - BIT_W'(1);
                    if (bitcnt_q == {BIT_W{1'b0}}) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Configuration load (length clamped) and saturating match counter.
    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        ovl_d = ovl_q;
        cnt_d = cnt_q;
        if (cfg_take_s) begin
            pat_d = cfg_pattern_i;
            len_d = (cfg_len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len_i;
            ovl_d = cfg_overlap_i;
            cnt_d = {CNT_W{1'b0}};
        end else if (hit_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Configuration and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= PAT_W'(DEF_PATTERN);
            len_q <= LEN_W'(DEF_LEN);
            ovl_q <= DEF_OVERLAP;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            ovl_q <= ovl_d;
            cnt_q <= cnt_d;
        end
    end

    seqdet_pat_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .strobe_i  (strobe_s),
        .bit_i     (shreg_q[DATA_W-1]),
        .clear_i   (clear_s),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .overlap_i (ovl_q),
        .hit_o     (hit_s),
        .match_o   (match_o)
    );

    assign in_bus.ready   = (state_q == IDLE);
    assign busy_o         = (state_q == SHIFT);
    assign serial_bit_o   = sbit_q;
    assign serial_valid_o = svalid_q;
    assign match_count_o  = cnt_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_seqdet_scan_ctrl.sv
// Randomized and directed bench for seqdet_scan_ctrl, checked against a bit-queue model.
module tb_seqdet_scan_ctrl;

    localparam int DATA_W = 16;
    localparam int PAT_W  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [4:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       sbit_a, svalid_a, match_a, busy_a, done_a;
    logic       sbit_b, svalid_b, match_b, busy_b, done_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    bit         m_hist[$];
    logic [4:0] m_pat;
    int         m_len;
    bit         m_ov;
    int         m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    seqdet_scan_ctrl_if #(.DATA_W(DATA_W)) bus_a ();
    seqdet_scan_ctrl_if #(.DATA_W(DATA_W)) bus_b ();

    assign bus_b.valid = bus_a.valid;
    assign bus_b.data  = bus_a.data;
    assign bus_b.last  = bus_a.last;

    seqdet_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_bus(bus_a),
        .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
        .cfg_overlap_i(cfg_overlap),
        .serial_bit_o(sbit_a), .serial_valid_o(svalid_a), .match_o(match_a),
        .match_count_o(cnt_a), .busy_o(busy_a), .done_o(done_a)
    );

    seqdet_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_bus(bus_b),
        .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
        .cfg_overlap_i(cfg_overlap),
        .serial_bit_o(sbit_b), .serial_valid_o(svalid_b), .match_o(match_b),
        .match_count_o(cnt_b), .busy_o(busy_b), .done_o(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_pat  = 5'b10110;
        m_len  = 5;
        m_ov   = 1'b1;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_cfg(input logic [4:0] p, input logic [2:0] l, input bit ov);
        m_pat  = p;
        m_len  = (int'(l) > PAT_W) ? PAT_W : int'(l);
        m_ov   = ov;
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_hist.delete();
    endtask

    // The last m_len bits seen since the last clear must equal the pattern, newest bit = pattern[0].
    task automatic model_bit(input bit b, output bit hit);
        m_hist.push_back(b);
        if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
        hit = 1'b0;
        if (m_len != 0 && m_hist.size() >= m_len) begin
            hit = 1'b1;
            for (int k = 0; k < m_len; k++) begin
                if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            end
        end
        if (hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
            if (!m_ov) m_hist.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, bus_a.ready}, 32'd1);
        chk({tag, "_sbit"}, {31'd0, sbit_a}, 32'd0);
        chk({tag, "_svalid"}, {31'd0, svalid_a}, 32'd0);
        chk({tag, "_match"}, {31'd0, match_a}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, cnt_a}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
        chk({tag, "_cnt2"}, {30'd0, cnt_b}, 32'd0);
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_a.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = bus_a.ready;
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic cfg_write(input logic [4:0] p, input logic [2:0] l, input bit ov);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
            @(posedge clk); #1;
            cfg_we = 1'b0;
            model_cfg(p, l, ov);
            chk("cfg_cnt_clear", {24'd0, cnt_a}, 32'd0);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input bit last,
                             input int cfg_bit = -1, input int rst_bit = -1,
                             input bit cfg_same = 1'b0,
                             input logic [4:0] c_pat = 5'b10110,
                             input logic [2:0] c_len = 3'd5, input bit c_ov = 1'b1);
        bit ok, hit;
        wait_ready(ok);
        if (!ok) return;
        bus_a.valid = 1'b1; bus_a.data = d; bus_a.last = last;
        if (cfg_same) begin
            cfg_we = 1'b1; cfg_pattern = c_pat; cfg_len = c_len; cfg_overlap = c_ov;
        end
        @(posedge clk); #1;
        bus_a.valid = 1'b0;
        cfg_we = 1'b0;
        if (cfg_same) model_cfg(c_pat, c_len, c_ov);
        chk("accept_busy", {31'd0, busy_a}, 32'd1);
        chk("accept_ready", {31'd0, bus_a.ready}, 32'd0);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            @(posedge clk); #1;
            cfg_we = 1'b0;
            model_bit(d[i], hit);
            chk("sbit", {31'd0, sbit_a}, {31'd0, d[i]});
            chk("svalid", {31'd0, svalid_a}, 32'd1);
            chk("match", {31'd0, match_a}, {31'd0, hit});
            chk("cnt8", {24'd0, cnt_a}, m_cnt8);
            chk("match_w2", {31'd0, match_b}, {31'd0, hit});
            chk("cnt2", {30'd0, cnt_b}, m_cnt2);
            chk("busy", {31'd0, busy_a}, (i != 0) ? 32'd1 : 32'd0);
            chk("ready", {31'd0, bus_a.ready}, (i != 0) ? 32'd0 : 32'd1);
            chk("done_early", {31'd0, done_a}, 32'd0);
            if (cfg_bit == i && i > 0) begin
                cfg_we = 1'b1; cfg_pattern = c_pat; cfg_len = c_len; cfg_overlap = c_ov;
            end
            if (rst_bit == i) begin
                #2 rst = 1'b1;
                #1 check_reset_outputs("abort");
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                return;
            end
        end
        if (last) m_hist.delete();
        @(posedge clk); #1;
        chk("done", {31'd0, done_a}, {31'd0, last});
        chk("done_w2", {31'd0, done_b}, {31'd0, last});
        chk("svalid_gap", {31'd0, svalid_a}, 32'd0);
        chk("match_gap", {31'd0, match_a}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_pattern = 5'd0; cfg_len = 3'd0; cfg_overlap = 1'b0;
        bus_a.valid = 1'b0; bus_a.data = 16'h0000; bus_a.last = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Defaults: three overlapping matches in 16'hB6C0.
        send_word(16'hB6C0, 1'b1);
        chk("dir_overlap_cnt", {24'd0, cnt_a}, 32'd3);

        // Non-overlapping: only two matches.
        cfg_write(5'b10110, 3'd5, 1'b0);
        send_word(16'hB6C0, 1'b1);
        chk("dir_nonoverlap_cnt", {24'd0, cnt_a}, 32'd2);

        // Match spanning a word boundary, and blocked by in_last.
        cfg_write(5'b10110, 3'd5, 1'b1);
        send_word(16'h0002, 1'b0);
        send_word(16'hC000, 1'b1);
        chk("dir_span_cnt", {24'd0, cnt_a}, 32'd1);
        cfg_write(5'b10110, 3'd5, 1'b1);
        send_word(16'h0002, 1'b1);
        send_word(16'hC000, 1'b0);
        chk("dir_nospan_cnt", {24'd0, cnt_a}, 32'd0);

        // Saturation of the 2-bit counter.
        cfg_write(5'b10110, 3'd5, 1'b1);
        send_word(16'hB6C0, 1'b0);
        send_word(16'hB6C0, 1'b1);
        chk("dir_sat_cnt2", {30'd0, cnt_b}, 32'd3);
        chk("dir_sat_cnt8", {24'd0, cnt_a}, 32'd6);

        // Write during SHIFT is ignored; the same write in IDLE takes effect.
        cfg_write(5'b10110, 3'd5, 1'b1);
        send_word(16'hB6C0, 1'b1, 12, -1, 1'b0, 5'b10110, 3'd0, 1'b1);
        chk("dir_busy_cfg_cnt", {24'd0, cnt_a}, 32'd3);
        cfg_write(5'b10110, 3'd0, 1'b1);
        send_word(16'hB6C0, 1'b1);
        chk("dir_len0_cnt", {24'd0, cnt_a}, 32'd0);

        // Reset at the sixth serial bit, then a clean word.
        cfg_write(5'b10110, 3'd5, 1'b1);
        send_word(16'hB6C0, 1'b0, -1, 10);
        send_word(16'hB6C0, 1'b1);
        chk("dir_after_abort_cnt", {24'd0, cnt_a}, 32'd3);

        // Configuration and word in the same IDLE cycle.
        send_word(16'hB6C0, 1'b1, -1, -1, 1'b1, 5'b10110, 3'd5, 1'b0);
        chk("dir_same_cycle_cnt", {24'd0, cnt_a}, 32'd2);

        // Randomized traffic with occasional reconfiguration, including clamped lengths.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_write(5'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
            end
            if ($urandom_range(0, 1) == 0) begin
                send_word(16'($urandom), 1'($urandom_range(0, 3) == 0));
            end else begin
                send_word({2{8'($urandom_range(0, 3) == 0 ? 8'hB6 : 8'($urandom))}},
                          1'($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
